// File: rtl/wall_elastic.sv
// wall_elastic
//   Elastic inter-stage wall carrying one writeback bundle (reg_wr, rd, payload)
//   per entry. It uses a valid/ready handshake backed by a two-entry skid buffer
//   (a main/head register plus a skid register), so a downstream stall never
//   drops or duplicates an entry. A synchronous flush empties the wall. A
//   saturating counter records the cycles in which the wall presents no entry.
//
// Ports
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   flush                  synchronous flush; discards held and incoming entries
//   in_valid/in_ready      upstream handshake (in_ready is registered)
//   in_reg_wr/in_rd/in_data  offered entry
//   out_valid/out_ready    downstream handshake
//   out_reg_wr/out_rd      head entry fields, forced to 0 when out_valid=0
//   out_data               head payload, held stable while the wall is idle
//   occupancy              entries held (0..2)
//   bubble_cnt             saturating count of cycles with out_valid=0
module wall_elastic #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_wr,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_wr,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // The encoding equals the number of held entries, so occupancy is the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;
  logic                main_wr_reg;
  logic [RD_W-1:0]     main_rd_reg;
  logic [DATA_W-1:0]   main_data_reg;
  logic                skid_wr_reg;
  logic [RD_W-1:0]     skid_rd_reg;
  logic [DATA_W-1:0]   skid_data_reg;
  logic [CNT_W-1:0]    bubble_cnt_reg;

  logic push;
  logic pop;

  assign push = in_valid & in_ready_reg;
  assign pop  = out_valid_reg & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= EMPTY;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      main_wr_reg    <= 1'b0;
      main_rd_reg    <= '0;
      main_data_reg  <= '0;
      skid_wr_reg    <= 1'b0;
      skid_rd_reg    <= '0;
      skid_data_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      // Bubble counter sticks at all-ones and deliberately ignores flush.
      if (!out_valid_reg && (bubble_cnt_reg != {CNT_W{1'b1}}))
        bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);

      if (flush) begin
        // Flush wins over push/pop; data registers are left untouched so the
        // idle payload stays stable.
        state_reg     <= EMPTY;
        out_valid_reg <= 1'b0;
        in_ready_reg  <= 1'b1;
      end else begin
        case (state_reg)
          EMPTY: begin
            if (push) begin
              main_wr_reg   <= in_reg_wr;
              main_rd_reg   <= in_rd;
              main_data_reg <= in_data;
              state_reg     <= ONE;
              out_valid_reg <= 1'b1;
            end
          end
          ONE: begin
            if (push && pop) begin
              main_wr_reg   <= in_reg_wr;
              main_rd_reg   <= in_rd;
              main_data_reg <= in_data;
            end else if (push) begin
              // Head is stalled: park the new entry behind it.
              skid_wr_reg   <= in_reg_wr;
              skid_rd_reg   <= in_rd;
              skid_data_reg <= in_data;
              state_reg     <= FULL;
              in_ready_reg  <= 1'b0;
            end else if (pop) begin
              state_reg     <= EMPTY;
              out_valid_reg <= 1'b0;
            end
          end
          FULL: begin
            // in_ready is low here, so only a pop can happen.
            if (pop) begin
              main_wr_reg   <= skid_wr_reg;
              main_rd_reg   <= skid_rd_reg;
              main_data_reg <= skid_data_reg;
              state_reg     <= ONE;
              in_ready_reg  <= 1'b1;
            end
          end
          default: begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  // Masking keeps an idle wall from ever requesting a register write.
  assign out_reg_wr = out_valid_reg & main_wr_reg;
  assign out_rd     = out_valid_reg ? main_rd_reg : '0;
  assign out_data   = main_data_reg;
  assign occupancy  = state_reg;
  assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: tb/tb_wall_elastic.sv
module tb_wall_elastic;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_reg_wr;
  logic [RD_W-1:0]   in_rd;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_reg_wr;
  logic [RD_W-1:0]   out_rd;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt;

  wall_elastic #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_wr(in_reg_wr), .in_rd(in_rd), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_reg_wr(out_reg_wr), .out_rd(out_rd), .out_data(out_data),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a bounded FIFO of entries plus a bubble counter.
  typedef struct {
    logic              wr;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } entry_t;
  entry_t m_q[$];
  int     m_bub;

  typedef struct {
    logic              v;
    logic              wr;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    logic              ordy;
    logic              fl;
    logic              e_valid;
    logic              e_wr;
    logic [RD_W-1:0]   e_rd;
    logic [1:0]        e_occ;
    logic              e_rdy;
  } vec_t;
  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    int sz;
    sz = m_q.size();
    chk("out_valid", 32'(out_valid), 32'(sz > 0));
    chk("in_ready", 32'(in_ready), 32'(sz < 2));
    chk("occupancy", 32'(occupancy), 32'(sz));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
    if (sz > 0) begin
      chk("out_rd", 32'(out_rd), 32'(m_q[0].rd));
      chk("out_reg_wr", 32'(out_reg_wr), 32'(m_q[0].wr));
      chk("out_data", out_data, m_q[0].data);
    end else begin
      chk("out_rd_masked", 32'(out_rd), 32'd0);
      chk("out_reg_wr_masked", 32'(out_reg_wr), 32'd0);
    end
  endtask

  // One clock: model consumes the inputs present at the edge, then outputs are
  // sampled 1 time unit later and compared.
  task automatic cycle();
    int     sz;
    bit     m_push;
    bit     m_pop;
    entry_t e;
    @(posedge clk);
    sz     = m_q.size();
    m_push = in_valid && (sz < 2);
    m_pop  = (sz > 0) && out_ready;
    if (sz == 0) m_bub = (m_bub >= CNT_MAX) ? CNT_MAX : m_bub + 1;
    if (flush) begin
      m_q.delete();
    end else begin
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        e.wr = in_reg_wr; e.rd = in_rd; e.data = in_data;
        m_q.push_back(e);
      end
    end
    #1;
    chk_model();
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_reg_wr = 0; in_rd = '0; in_data = '0; out_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_q.delete();
    m_bub = 0;

    // Reset values
    #13;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_reg_wr", 32'(out_reg_wr), 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_bubble", 32'(bubble_cnt), 32'd0);
    #10 rst = 1'b0;

    // Saturation: idle 20 cycles, then flush must not clear the count
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_bubble_15", 32'(bubble_cnt), 32'd15);
    flush = 1;
    cycle();
    flush = 0;
    chk("sat_after_flush", 32'(bubble_cnt), 32'd15);
    $display("saturation: bubble_cnt=%0d", bubble_cnt);

    // Directed table: streaming, stall/skid, flush, mask
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 1'(i), 5'(i + 1), 32'h10 + 32'(i), 1'b1, 1'b0,
                  1'b1, 1'(i), 5'(i + 1), 2'd1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 5'd3,  32'h30, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3,  2'd1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 5'd4,  32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3,  2'd2, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 5'd9,  32'h90, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3,  2'd2, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd4,  2'd1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 5'd5,  32'h50, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  2'd1, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 5'd6,  32'h60, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  2'd2, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 5'd7,  32'h70, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  2'd0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 1'b1};
    vecs[18] = '{1'b1, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 2'd1, 1'b1};
    vecs[19] = '{1'b1, 1'b1, 5'd11, 32'hB0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  2'd0, 1'b1};
    vecs[20] = '{1'b0, 1'b1, 5'd12, 32'hC0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 1'b1};
    vecs[21] = '{1'b0, 1'b1, 5'd13, 32'hD0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 1'b1};

    for (int i = 0; i < 22; i++) begin
      in_valid = vecs[i].v; in_reg_wr = vecs[i].wr; in_rd = vecs[i].rd;
      in_data = vecs[i].data; out_ready = vecs[i].ordy; flush = vecs[i].fl;
      cycle();
      chk("tab_valid", 32'(out_valid), 32'(vecs[i].e_valid));
      chk("tab_reg_wr", 32'(out_reg_wr), 32'(vecs[i].e_wr));
      chk("tab_rd", 32'(out_rd), 32'(vecs[i].e_rd));
      chk("tab_occ", 32'(occupancy), 32'(vecs[i].e_occ));
      chk("tab_in_ready", 32'(in_ready), 32'(vecs[i].e_rdy));
      $display("vec %0d: valid=%0d rd=%0d occ=%0d in_ready=%0d", i, out_valid, out_rd, occupancy, in_ready);
    end
    idle_inputs();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      in_reg_wr = 1'($urandom);
      in_rd     = 5'($urandom);
      in_data   = $urandom;
      cycle();
    end
    $display("random: %0d cycles done, occupancy=%0d", 400, occupancy);

    // Reset mid-traffic: fill the wall, then assert rst between edges
    idle_inputs();
    flush = 1;
    cycle();
    flush = 0;
    in_valid = 1; in_reg_wr = 1; in_rd = 5'd20; in_data = 32'hAAAA0001;
    cycle();
    in_rd = 5'd21; in_data = 32'hAAAA0002;
    cycle();
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    chk("async_rst_occ", 32'(occupancy), 32'd0);
    chk("async_rst_rd", 32'(out_rd), 32'd0);
    chk("async_rst_bubble", 32'(bubble_cnt), 32'd0);
    @(posedge clk);
    #1;
    chk("held_rst_occ", 32'(occupancy), 32'd0);
    chk("held_rst_bubble", 32'(bubble_cnt), 32'd0);
    #3 rst = 1'b0;
    m_q.delete();
    m_bub = 0;
    $display("reset mid-traffic applied");

    // Post-reset traffic
    cycle();
    chk("post_rst_bubble", 32'(bubble_cnt), 32'd1);
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_reg_wr = 1'(i); in_rd = 5'(i + 24); in_data = 32'h100 + 32'(i);
      cycle();
      chk("post_rst_stream_rd", 32'(out_rd), 32'(i + 24));
    end
    idle_inputs();
    out_ready = 1;
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
